// File: rtl/dmi_jtag_sequencer.sv
// One-shot DMI transaction engine between the JTAG DMI shift register and
// the debug module. Each Update-DR launches at most one request, waits for
// the response, and holds read data plus a sticky busy/failed status for the
// next Capture-DR.
module dmi_jtag_sequencer #(
    parameter int AddrWidth     = 7,
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 1024,
    parameter int CntWidth      = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 update_i,
    input  logic [1:0]           op_i,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [DataWidth-1:0] data_i,
    input  logic                 dmireset_i,
    input  logic                 dmihardreset_i,
    output logic                 dmi_req_valid_o,
    input  logic                 dmi_req_ready_i,
    output logic [1:0]           dmi_req_op_o,
    output logic [AddrWidth-1:0] dmi_req_addr_o,
    output logic [DataWidth-1:0] dmi_req_data_o,
    input  logic                 dmi_resp_valid_i,
    output logic                 dmi_resp_ready_o,
    input  logic [1:0]           dmi_resp_resp_i,
    input  logic [DataWidth-1:0] dmi_resp_data_i,
    output logic [1:0]           capture_op_o,
    output logic [DataWidth-1:0] capture_data_o,
    output logic                 busy_o
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP} state_e;

    typedef struct packed {
        logic [1:0]           op;
        logic [AddrWidth-1:0] addr;
        logic [DataWidth-1:0] data;
    } dmi_req_t;

    localparam logic [1:0] OP_READ    = 2'd1;
    localparam logic [1:0] OP_WRITE   = 2'd2;
    localparam logic [1:0] ST_FAILED  = 2'd2;
    localparam logic [1:0] ST_BUSY    = 2'd3;

    state_e               state;
    dmi_req_t             req_q;
    logic [1:0]           sticky;
    logic [CntWidth-1:0]  cnt;
    logic [DataWidth-1:0] cap_data;

    logic       is_access;
    logic       resp_fire;
    logic       timeout_hit;
    logic       err_evt;
    logic [1:0] err_code;

    assign is_access = (op_i == OP_READ) || (op_i == OP_WRITE);
    assign resp_fire = (state == WAIT_RESP) && dmi_resp_valid_i;
    // Timeout only fires when no response arrives on the final allowed cycle.
    assign timeout_hit = (TimeoutCycles != 0) && (state == WAIT_RESP) && !dmi_resp_valid_i
                         && (cnt == CntWidth'(TimeoutCycles - 1));

    assign busy_o           = (state != IDLE);
    assign dmi_req_valid_o  = (state == REQ);
    assign dmi_resp_ready_o = (state == WAIT_RESP);
    assign dmi_req_op_o     = req_q.op;
    assign dmi_req_addr_o   = req_q.addr;
    assign dmi_req_data_o   = req_q.data;
    assign capture_data_o   = cap_data;
    assign capture_op_o     = (sticky != 2'd0) ? sticky : (busy_o ? ST_BUSY : 2'd0);

    // Classify this cycle's error event; a failed/timed-out transaction
    // outranks an overlapping update arriving on the same cycle.
    always_comb begin
        err_evt  = 1'b0;
        err_code = 2'd0;
        if ((resp_fire && dmi_resp_resp_i != 2'd0) || timeout_hit) begin
            err_evt  = 1'b1;
            err_code = ST_FAILED;
        end else if (update_i && busy_o) begin
            err_evt  = 1'b1;
            err_code = ST_BUSY;
        end
    end

    // Transaction FSM, sticky status, timeout counter and capture data.
    always_ff @(posedge clk_i) begin
        if (rst_i || dmihardreset_i) begin
            state    <= IDLE;
            req_q    <= '0;
            sticky   <= 2'd0;
            cnt      <= '0;
            cap_data <= '0;
        end else begin
            // First error wins; dmireset clears unless a new error lands now.
            if (dmireset_i)
                sticky <= err_evt ? err_code : 2'd0;
            else if (sticky == 2'd0 && err_evt)
                sticky <= err_code;

            case (state)
                IDLE: begin
                    if (update_i && is_access && sticky == 2'd0) begin
                        req_q <= '{op: op_i, addr: addr_i, data: data_i};
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (dmi_req_ready_i) state <= WAIT_RESP;
                end
                WAIT_RESP: begin
                    if (dmi_resp_valid_i) begin
                        state <= IDLE;
                        cnt   <= '0;
                        if (req_q.op == OP_READ) cap_data <= dmi_resp_data_i;
                    end else if (timeout_hit) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CntWidth'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmi_jtag_sequencer.sv
// Directed bench for dmi_jtag_sequencer: expected requests go into a queue
// when an update is driven and are popped when the DUT handshakes.
module tb_dmi_jtag_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        update_i = 1'b0;
    logic [1:0]  op_i = 2'd0;
    logic [6:0]  addr_i = 7'd0;
    logic [31:0] data_i = 32'd0;
    logic        dmireset_i = 1'b0;
    logic        dmihardreset_i = 1'b0;
    logic        dmi_req_valid_o;
    logic        dmi_req_ready_i = 1'b1;
    logic [1:0]  dmi_req_op_o;
    logic [6:0]  dmi_req_addr_o;
    logic [31:0] dmi_req_data_o;
    logic        dmi_resp_valid_i = 1'b0;
    logic        dmi_resp_ready_o;
    logic [1:0]  dmi_resp_resp_i = 2'd0;
    logic [31:0] dmi_resp_data_i = 32'd0;
    logic [1:0]  capture_op_o;
    logic [31:0] capture_data_o;
    logic        busy_o;

    typedef struct {
        logic [1:0]  op;
        logic [6:0]  addr;
        logic [31:0] data;
    } req_t;

    req_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   hs_cnt = 0;

    dmi_jtag_sequencer #(
        .AddrWidth(7), .DataWidth(32), .TimeoutCycles(8), .CntWidth(16)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .update_i(update_i), .op_i(op_i),
        .addr_i(addr_i), .data_i(data_i), .dmireset_i(dmireset_i),
        .dmihardreset_i(dmihardreset_i), .dmi_req_valid_o(dmi_req_valid_o),
        .dmi_req_ready_i(dmi_req_ready_i), .dmi_req_op_o(dmi_req_op_o),
        .dmi_req_addr_o(dmi_req_addr_o), .dmi_req_data_o(dmi_req_data_o),
        .dmi_resp_valid_i(dmi_resp_valid_i), .dmi_resp_ready_o(dmi_resp_ready_o),
        .dmi_resp_resp_i(dmi_resp_resp_i), .dmi_resp_data_i(dmi_resp_data_i),
        .capture_op_o(capture_op_o), .capture_data_o(capture_data_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Handshake monitor: ready/valid are stable mid-cycle, so the transfer
    // seen here is the one taken at the next rising edge.
    always @(negedge clk_i) begin
        if (!rst_i && !dmihardreset_i && dmi_req_valid_o && dmi_req_ready_i) begin
            hs_cnt++;
            check("req_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                req_t e;
                e = exp_q.pop_front();
                check("req_op",   32'(dmi_req_op_o),   32'(e.op));
                check("req_addr", 32'(dmi_req_addr_o), 32'(e.addr));
                check("req_data", dmi_req_data_o,      e.data);
            end
        end
    end

    task automatic pulse_update(input logic [1:0] op, input logic [6:0] addr,
                                input logic [31:0] data, input bit expect_req);
        req_t r;
        r.op = op; r.addr = addr; r.data = data;
        if (expect_req) exp_q.push_back(r);
        update_i = 1'b1; op_i = op; addr_i = addr; data_i = data;
        step();
        update_i = 1'b0;
    endtask

    // Full transaction with ready already high; response 3 cycles later.
    task automatic do_txn(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] wdata,
                          input logic [1:0] resp, input logic [31:0] rdata);
        pulse_update(op, addr, wdata, 1'b1);
        check("txn_valid_n1", 32'(dmi_req_valid_o), 32'd1);
        check("txn_busy_n1",  32'(busy_o), 32'd1);
        step();
        check("txn_valid_drop", 32'(dmi_req_valid_o), 32'd0);
        check("txn_resp_ready", 32'(dmi_resp_ready_o), 32'd1);
        step();
        step();
        check("txn_busy_wait", 32'(busy_o), 32'd1);
        dmi_resp_valid_i = 1'b1; dmi_resp_resp_i = resp; dmi_resp_data_i = rdata;
        step();
        dmi_resp_valid_i = 1'b0; dmi_resp_resp_i = 2'd0;
        check("txn_busy_done", 32'(busy_o), 32'd0);
    endtask

    task automatic pulse_dmireset();
        dmireset_i = 1'b1;
        step();
        dmireset_i = 1'b0;
    endtask

    initial begin
        int hs_before;

        // Reset state
        step(); step();
        rst_i = 1'b0;
        check("rst_valid",   32'(dmi_req_valid_o), 32'd0);
        check("rst_rready",  32'(dmi_resp_ready_o), 32'd0);
        check("rst_busy",    32'(busy_o), 32'd0);
        check("rst_cap_op",  32'(capture_op_o), 32'd0);
        check("rst_cap_dat", capture_data_o, 32'd0);

        // READ
        do_txn(2'd1, 7'h11, 32'd0, 2'd0, 32'h0000_3A82);
        check("read_cap_data", capture_data_o, 32'h0000_3A82);
        check("read_cap_op",   32'(capture_op_o), 32'd0);
        check("read_hs",       32'(hs_cnt), 32'd1);

        // WRITE with ready held low 5 cycles
        dmi_req_ready_i = 1'b0;
        pulse_update(2'd2, 7'h10, 32'h8000_0001, 1'b1);
        for (int i = 0; i < 6; i++) begin
            if (i == 5) dmi_req_ready_i = 1'b1;
            check("wr_valid_hold", 32'(dmi_req_valid_o), 32'd1);
            check("wr_op_hold",    32'(dmi_req_op_o), 32'd2);
            check("wr_addr_hold",  32'(dmi_req_addr_o), 32'h10);
            check("wr_data_hold",  dmi_req_data_o, 32'h8000_0001);
            check("wr_cap_op_busy", 32'(capture_op_o), 32'd3);
            step();
        end
        check("wr_valid_drop", 32'(dmi_req_valid_o), 32'd0);
        dmi_resp_valid_i = 1'b1; dmi_resp_data_i = 32'hDEAD_BEEF;
        step();
        dmi_resp_valid_i = 1'b0;
        check("wr_cap_data", capture_data_o, 32'h0000_3A82);
        check("wr_cap_op",   32'(capture_op_o), 32'd0);
        check("wr_hs",       32'(hs_cnt), 32'd2);

        // Overlap during WAIT_RESP
        pulse_update(2'd1, 7'h05, 32'd0, 1'b1);
        step();
        check("ov_rready", 32'(dmi_resp_ready_o), 32'd1);
        pulse_update(2'd1, 7'h06, 32'd0, 1'b0);
        check("ov_cap_op", 32'(capture_op_o), 32'd3);
        dmi_resp_valid_i = 1'b1; dmi_resp_data_i = 32'h0000_1234;
        step();
        dmi_resp_valid_i = 1'b0;
        check("ov_cap_op_after", 32'(capture_op_o), 32'd3);
        check("ov_cap_data",     capture_data_o, 32'h0000_1234);
        hs_before = hs_cnt;
        pulse_update(2'd1, 7'h07, 32'd0, 1'b0);
        check("ov_blocked_valid", 32'(dmi_req_valid_o), 32'd0);
        step();
        check("ov_blocked_busy", 32'(busy_o), 32'd0);
        check("ov_blocked_hs",   32'(hs_cnt), 32'(hs_before));
        pulse_dmireset();
        check("ov_cleared", 32'(capture_op_o), 32'd0);
        do_txn(2'd1, 7'h08, 32'd0, 2'd0, 32'h0000_55AA);
        check("ov_next_read", capture_data_o, 32'h0000_55AA);

        // Failed response
        do_txn(2'd1, 7'h09, 32'd0, 2'd2, 32'h0000_0077);
        check("fail_cap_op",   32'(capture_op_o), 32'd2);
        check("fail_cap_data", capture_data_o, 32'h0000_0077);
        pulse_dmireset();
        check("fail_cleared", 32'(capture_op_o), 32'd0);

        // Timeout after 8 cycles in WAIT_RESP
        pulse_update(2'd1, 7'h0A, 32'd0, 1'b1);
        step();
        for (int i = 0; i < 8; i++) begin
            check("to_busy_wait", 32'(busy_o), 32'd1);
            step();
        end
        check("to_busy_drop", 32'(busy_o), 32'd0);
        check("to_cap_op",    32'(capture_op_o), 32'd2);
        check("to_rready",    32'(dmi_resp_ready_o), 32'd0);
        dmi_resp_valid_i = 1'b1; dmi_resp_data_i = 32'h0000_0BAD;
        step();
        dmi_resp_valid_i = 1'b0;
        check("to_late_ignored", capture_data_o, 32'h0000_0077);
        check("to_late_op",      32'(capture_op_o), 32'd2);
        pulse_dmireset();

        // Hard reset while in REQ
        dmi_req_ready_i = 1'b0;
        pulse_update(2'd1, 7'h0B, 32'h1111_2222, 1'b0);
        check("hr_in_req", 32'(dmi_req_valid_o), 32'd1);
        dmihardreset_i = 1'b1;
        step();
        dmihardreset_i = 1'b0;
        dmi_req_ready_i = 1'b1;
        check("hr_valid",    32'(dmi_req_valid_o), 32'd0);
        check("hr_busy",     32'(busy_o), 32'd0);
        check("hr_cap_op",   32'(capture_op_o), 32'd0);
        check("hr_cap_data", capture_data_o, 32'd0);
        check("hr_addr",     32'(dmi_req_addr_o), 32'd0);

        // rst_i in the middle of WAIT_RESP
        do_txn(2'd1, 7'h0C, 32'd0, 2'd0, 32'h0000_0099);
        pulse_update(2'd1, 7'h0D, 32'd0, 1'b1);
        step();
        check("rst_mid_wait", 32'(dmi_resp_ready_o), 32'd1);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("rst_mid_busy",   32'(busy_o), 32'd0);
        check("rst_mid_rready", 32'(dmi_resp_ready_o), 32'd0);
        check("rst_mid_data",   capture_data_o, 32'd0);

        // NOP and reserved ops
        hs_before = hs_cnt;
        pulse_update(2'd0, 7'h01, 32'd0, 1'b0);
        check("nop_valid", 32'(dmi_req_valid_o), 32'd0);
        check("nop_busy",  32'(busy_o), 32'd0);
        pulse_update(2'd3, 7'h02, 32'd0, 1'b0);
        check("rsv_valid", 32'(dmi_req_valid_o), 32'd0);
        check("rsv_busy",  32'(busy_o), 32'd0);
        step();
        check("nop_hs", 32'(hs_cnt), 32'(hs_before));

        // Error events coinciding with dmireset: the new code is kept
        pulse_update(2'd1, 7'h0E, 32'd0, 1'b1);
        step();
        dmireset_i = 1'b1;
        pulse_update(2'd1, 7'h0F, 32'd0, 1'b0);
        dmireset_i = 1'b0;
        check("rst_err_busy_code", 32'(capture_op_o), 32'd3);
        dmireset_i = 1'b1;
        dmi_resp_valid_i = 1'b1; dmi_resp_resp_i = 2'd2; dmi_resp_data_i = 32'h0000_0042;
        step();
        dmireset_i = 1'b0; dmi_resp_valid_i = 1'b0; dmi_resp_resp_i = 2'd0;
        check("rst_err_fail_code", 32'(capture_op_o), 32'd2);
        check("rst_err_data",      capture_data_o, 32'h0000_0042);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
